// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with PC, single-outstanding bus handshake, 2-entry fetch queue and redirect
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   jump_flag_i    redirect request; jump_addr_i is the new PC
//   hold_i         decode stall, head entry is not consumed
//   ibus_req_o     fetch request, ibus_addr_o is the fetch address (the PC)
//   ibus_gnt_i     request accepted this cycle
//   ibus_rvalid_i  read data valid, ibus_rdata_i is the fetched word
//   inst_o         instruction to decode, inst_addr_o its address, inst_valid_o marks it real
//
// Optional feature macro: FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch #(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         INST_WIDTH      = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jump_flag_i,
    input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                       hold_i,
    output logic                       ibus_req_o,
    output logic [INST_ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                       ibus_gnt_i,
    input  logic                       ibus_rvalid_i,
    input  logic [INST_WIDTH-1:0]      ibus_rdata_i,
    output logic [INST_WIDTH-1:0]      inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                       inst_valid_o
);
    localparam logic [1:0]            S_IDLE  = 2'd0;
    localparam logic [1:0]            S_WAIT  = 2'd1;
    localparam logic [1:0]            S_DRAIN = 2'd2;
    localparam logic [INST_WIDTH-1:0] NOP     = INST_WIDTH'(32'h0000_0013);

    logic [1:0]                 r_state;
    logic                       r_run;
    logic [INST_ADDR_WIDTH-1:0] r_pc;
    logic [INST_ADDR_WIDTH-1:0] r_req_addr;
    logic [INST_ADDR_WIDTH-1:0] r_qa [2];
    logic [INST_WIDTH-1:0]      r_qd [2];
    logic                       r_wp;
    logic                       r_rp;
    logic [1:0]                 r_count;

    logic       w_accept;
    logic       w_rsp;
    logic       w_has;
    logic       w_byp;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_state_nxt;

    // r_run holds the request low until the first edge after reset release
    assign ibus_req_o  = r_run & (r_state == S_IDLE) & (r_count != 2'd2) & ~jump_flag_i;
    assign ibus_addr_o = r_pc;
    assign w_accept    = ibus_req_o & ibus_gnt_i;
    assign w_rsp       = (r_state == S_WAIT) & ibus_rvalid_i & ~jump_flag_i;
    assign w_has       = r_count != 2'd0;
`ifdef FETCH_BYPASS_EN
    assign w_byp       = ~w_has & w_rsp;
`else
    assign w_byp       = 1'b0;
`endif
    // a bypassed word consumed by decode this cycle never enters the queue
    assign w_push      = w_rsp & ~(w_byp & ~hold_i);
    assign w_pop       = w_has & ~hold_i;

    assign inst_valid_o = w_has | w_byp;
    assign inst_o       = w_has ? r_qd[r_rp] : (w_byp ? ibus_rdata_i : NOP);
    assign inst_addr_o  = w_has ? r_qa[r_rp] : (w_byp ? r_req_addr : '0);

    // a redirect without data in WAIT leaves a response in flight, which DRAIN swallows
    assign w_state_nxt = (r_state == S_IDLE) ? (w_accept ? S_WAIT : S_IDLE) :
                         ibus_rvalid_i ? S_IDLE :
                         (r_state == S_WAIT) ? (jump_flag_i ? S_DRAIN : S_WAIT) :
                         (r_state == S_DRAIN) ? S_DRAIN : S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_qa[0]    <= '0;
            r_qa[1]    <= '0;
            r_qd[0]    <= '0;
            r_qd[1]    <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            if (jump_flag_i) begin
                r_pc <= jump_addr_i;
            end else if (w_accept) begin
                r_pc       <= r_pc + INST_ADDR_WIDTH'(4);
                r_req_addr <= r_pc;
            end
            if (jump_flag_i) begin
                r_count <= 2'd0;
                r_wp    <= 1'b0;
                r_rp    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_qa[r_wp] <= r_req_addr;
                    r_qd[r_wp] <= ibus_rdata_i;
                    r_wp       <= ~r_wp;
                end
                if (w_pop) r_rp <= ~r_rp;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && r_count == 2'd2));

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int n_chk = 0;
    int n_fail = 0;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cyc_n = 0;
    int          pop_n = 0;
    int          acc_n = 0;
    logic [31:0] pop_a [32];
    logic [31:0] pop_d [32];
    int          pop_t [32];
    logic [31:0] acc_a [32];
    int          acc_t [32];

    if_fetch dut (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
        .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b0; jump_flag_i = 1'b0; hold_i = 1'b0; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b0; ibus_rdata_i = '0; pend = 1'b0;
        cyc_n = 0; pop_n = 0; acc_n = 0;
        tick;
        tick;
        rst = 1'b1;
        tick;
    endtask

    // one cycle of a slave that answers every accept exactly one cycle later
    task automatic auto_cycle;
        ibus_rvalid_i = pend;
        ibus_rdata_i  = pend ? dat(pend_addr) : '0;
        #1;
        if (inst_valid_o && !hold_i && pop_n < 32) begin
            pop_a[pop_n] = inst_addr_o; pop_d[pop_n] = inst_o; pop_t[pop_n] = cyc_n; pop_n++;
        end
        pend = ibus_req_o && ibus_gnt_i;
        pend_addr = ibus_addr_o;
        if (pend && acc_n < 32) begin
            acc_a[acc_n] = ibus_addr_o; acc_t[acc_n] = cyc_n; acc_n++;
        end
        tick;
        cyc_n++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        n_chk++; if (ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", ibus_req_o); end
        n_chk++; if (ibus_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", ibus_addr_o); end
        n_chk++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
        n_chk++; if (inst_o !== 32'h13) begin n_fail++; $display("FAIL rst_inst: got %h want 00000013", inst_o); end
        n_chk++; if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_iaddr: got %h want 0", inst_addr_o); end
        tick;
        rst = 1'b1;
        #1;
        n_chk++; if (ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL rel_req_early: got %b want 0", ibus_req_o); end
        tick;
        n_chk++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rel_req: got req=%b addr=%h want req=1 addr=0", ibus_req_o, ibus_addr_o); end
    endtask

    task automatic test_basic;
        int lat;
`ifdef FETCH_BYPASS_EN
        lat = 1;
`else
        lat = 2;
`endif
        do_reset;
        ibus_gnt_i = 1'b1;
        repeat (12) auto_cycle;
        n_chk++; if (pop_n < 4) begin n_fail++; $display("FAIL basic_count: got %0d pops want >=4", pop_n); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++; if (pop_a[i] !== 32'(4 * i) || pop_d[i] !== 32'hA0 + 32'(i)) begin
                    n_fail++; $display("FAIL basic_pop%0d: got %h/%h want %h/%h", i, pop_a[i], pop_d[i], 4 * i, 32'hA0 + 32'(i)); end
                n_chk++; if (pop_t[i] - pop_t[0] !== 2 * i) begin
                    n_fail++; $display("FAIL basic_rate%0d: got %0d want %0d", i, pop_t[i] - pop_t[0], 2 * i); end
            end
            n_chk++; if (pop_t[0] - acc_t[0] !== lat) begin
                n_fail++; $display("FAIL basic_latency: got %0d want %0d", pop_t[0] - acc_t[0], lat); end
        end
    endtask

    task automatic test_hold;
        do_reset;
        ibus_gnt_i = 1'b1;
        hold_i = 1'b1;
        repeat (10) auto_cycle;
        n_chk++; if (acc_n !== 2) begin n_fail++; $display("FAIL hold_accepts: got %0d want 2", acc_n); end
        ibus_rvalid_i = 1'b0;
        #1;
        n_chk++; if (ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", ibus_req_o); end
        n_chk++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== 32'hA0) begin
            n_fail++; $display("FAIL hold_head: got v=%b %h/%h want v=1 0/a0", inst_valid_o, inst_addr_o, inst_o); end
        hold_i = 1'b0;
        pop_n = 0;
        acc_n = 0;
        repeat (8) auto_cycle;
        n_chk++; if (pop_n < 3) begin n_fail++; $display("FAIL hold_pops: got %0d want >=3", pop_n); end
        else begin
            n_chk++; if (pop_a[0] !== 32'h0 || pop_a[1] !== 32'h4 || pop_a[2] !== 32'h8) begin
                n_fail++; $display("FAIL hold_order: got %h %h %h want 0 4 8", pop_a[0], pop_a[1], pop_a[2]); end
            n_chk++; if (pop_t[1] - pop_t[0] !== 1) begin
                n_fail++; $display("FAIL hold_consec: got %0d want 1", pop_t[1] - pop_t[0]); end
        end
        n_chk++; if (acc_n < 1 || acc_a[0] !== 32'h8) begin
            n_fail++; $display("FAIL hold_resume: got n=%0d addr=%h want addr 8", acc_n, acc_a[0]); end
    endtask

    task automatic test_redirect_wait;
        do_reset;
        ibus_gnt_i = 1'b1;
        auto_cycle;
        jump_flag_i = 1'b1; jump_addr_i = 32'h100; ibus_rvalid_i = 1'b0;
        #1;
        n_chk++; if (ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_req_jump: got %b want 0", ibus_req_o); end
        tick;
        jump_flag_i = 1'b0;
        #1;
        n_chk++; if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rw_drain: got req=%b v=%b want 0 0", ibus_req_o, inst_valid_o); end
        tick;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (inst_valid_o !== 1'b0 || ibus_req_o !== 1'b0) begin
            n_fail++; $display("FAIL rw_discard: got v=%b req=%b want 0 0", inst_valid_o, ibus_req_o); end
        tick;
        ibus_rvalid_i = 1'b0;
        #1;
        n_chk++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rw_refetch: got req=%b addr=%h v=%b want 1 100 0", ibus_req_o, ibus_addr_o, inst_valid_o); end
        tick;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h111; hold_i = 1'b1;
        tick;
        ibus_rvalid_i = 1'b0;
        #1;
        n_chk++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== 32'h111) begin
            n_fail++; $display("FAIL rw_target: got v=%b %h/%h want 1 100/111", inst_valid_o, inst_addr_o, inst_o); end
        hold_i = 1'b0;
    endtask

    task automatic test_redirect_pop;
        do_reset;
        ibus_gnt_i = 1'b1;
        hold_i = 1'b1;
        repeat (3) auto_cycle;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hA1; hold_i = 1'b0;
        jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        #1;
        n_chk++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || ibus_req_o !== 1'b0) begin
            n_fail++; $display("FAIL rp_before: got v=%b a=%h req=%b want 1 0 0", inst_valid_o, inst_addr_o, ibus_req_o); end
        tick;
        jump_flag_i = 1'b0; ibus_rvalid_i = 1'b0; pend = 1'b0;
        #1;
        n_chk++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || inst_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rp_flush: got v=%b %h/%h want 0 0/13", inst_valid_o, inst_addr_o, inst_o); end
        n_chk++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h200) begin
            n_fail++; $display("FAIL rp_target: got req=%b addr=%h want 1 200", ibus_req_o, ibus_addr_o); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        ibus_gnt_i = 1'b1;
        hold_i = 1'b1;
        repeat (3) auto_cycle;
        ibus_rvalid_i = 1'b0;
        rst = 1'b0;
        #1;
        n_chk++; if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rm_bus: got req=%b addr=%h want 0 0", ibus_req_o, ibus_addr_o); end
        n_chk++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || inst_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL rm_out: got v=%b %h/%h want 0 0/13", inst_valid_o, inst_addr_o, inst_o); end
        tick;
        rst = 1'b1; hold_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0_0BAD; pend = 1'b0;
        #1;
        n_chk++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_late: got %b want 0", inst_valid_o); end
        tick;
        ibus_rvalid_i = 1'b0;
        #1;
        n_chk++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rm_restart: got req=%b addr=%h v=%b want 1 0 0", ibus_req_o, ibus_addr_o, inst_valid_o); end
    endtask

    task automatic test_wrap;
        do_reset;
        jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        #1;
        n_chk++; if (ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL wr_req_jump: got %b want 0", ibus_req_o); end
        tick;
        jump_flag_i = 1'b0; ibus_gnt_i = 1'b1;
        #1;
        n_chk++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wr_req: got req=%b addr=%h want 1 fffffffc", ibus_req_o, ibus_addr_o); end
        tick;
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h0001_3579; hold_i = 1'b1;
        tick;
        ibus_rvalid_i = 1'b0; hold_i = 1'b0;
        #1;
        n_chk++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hFFFF_FFFC || inst_o !== 32'h0001_3579) begin
            n_fail++; $display("FAIL wr_inst: got v=%b %h/%h want 1 fffffffc/00013579", inst_valid_o, inst_addr_o, inst_o); end
        n_chk++; if (ibus_addr_o !== 32'h0) begin n_fail++; $display("FAIL wr_pc: got %h want 0", ibus_addr_o); end
    endtask

    task automatic test_latency;
        do_reset;
        ibus_gnt_i = 1'b1;
        tick;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'h0050_0093; hold_i = 1'b0;
        #1;
`ifdef FETCH_BYPASS_EN
        n_chk++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0050_0093 || inst_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL lat_bypass: got v=%b %h/%h want 1 0/00500093", inst_valid_o, inst_addr_o, inst_o); end
`else
        n_chk++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_rsp_cycle: got %b want 0", inst_valid_o); end
`endif
        tick;
        ibus_rvalid_i = 1'b0;
        #1;
`ifdef FETCH_BYPASS_EN
        n_chk++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_consumed: got %b want 0", inst_valid_o); end
`else
        n_chk++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0050_0093 || inst_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL lat_queued: got v=%b %h/%h want 1 0/00500093", inst_valid_o, inst_addr_o, inst_o); end
`endif
        n_chk++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h4) begin
            n_fail++; $display("FAIL lat_next_req: got req=%b addr=%h want 1 4", ibus_req_o, ibus_addr_o); end
        tick;
        #1;
        n_chk++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h4) begin
            n_fail++; $display("FAIL lat_addr_stable: got req=%b addr=%h want 1 4", ibus_req_o, ibus_addr_o); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_redirect_wait;
        test_redirect_pop;
        test_reset_mid;
        test_wrap;
        test_latency;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage with PC register, instruction-bus request/response handshake, 2-entry fetch queue and redirect handling. It issues word fetches on the instruction bus and buffers returned words with their addresses. It presents them to the decode stage as `inst`/`inst_addr` plus a valid flag, and honours stall (`hold_i`) and branch/jump redirect (`jump_flag_i`) from the execute/control stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded at reset; word aligned.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `jump_flag_i`  in  1  redirect request from execute.
- `jump_addr_i`  in  `INST_ADDR_WIDTH`  redirect target.
- `hold_i`  in  1  decode stall; head entry not consumed.
- `ibus_req_o`  out  1  fetch request.
- `ibus_addr_o`  out  `INST_ADDR_WIDTH`  fetch address (= PC register).
- `ibus_gnt_i`  in  1  request accepted this cycle.
- `ibus_rvalid_i`  in  1  read data valid.
- `ibus_rdata_i`  in  `INST_WIDTH`  fetched word.
- `inst_o`  out  `INST_WIDTH`  instruction to decode.
- `inst_addr_o`  out  `INST_ADDR_WIDTH`  address of `inst_o`.
- `inst_valid_o`  out  1  `inst_o` holds a real instruction.

## Operation
- At most one outstanding bus transaction. Accept = `ibus_req_o & ibus_gnt_i`. Response arrives ≥1 cycle after accept.
- FSM states:
  - IDLE:
    - `ibus_req_o = (count < 2) & ~jump_flag_i`.
    - On accept: latch `req_addr <= pc`, `pc <= pc + 4`, go to WAIT.
  - WAIT: `ibus_req_o = 0`.
    - On `ibus_rvalid_i` without redirect: push {`req_addr`, `ibus_rdata_i`}, go to IDLE.
    - On redirect with `ibus_rvalid_i`: data discarded, go to IDLE.
    - On redirect without `ibus_rvalid_i`: go to DRAIN.
  - DRAIN: `ibus_req_o = 0`. Next `ibus_rvalid_i` is discarded, then go to IDLE.
- `ibus_addr_o` is held stable while `ibus_req_o` is high and `gnt` is low.
- Queue: 2 entries of {addr, inst}, with `count` 0..2 and wrap-around read/write pointers.
  - Pop when `inst_valid_o & ~hold_i`.
  - Push and pop in the same cycle leave `count` unchanged.
  - A push never occurs at `count`==2. The request gating guarantees this; an assertion checks it.
- Output: if `count`>0, drive the head entry with `inst_valid_o`=1. Otherwise drive `inst_o`=32'h0000_0013 (NOP), `inst_addr_o`=0, `inst_valid_o`=0.
- Redirect (`jump_flag_i`=1), any state:
  - Next edge: `pc <= jump_addr_i`, queue flushed (`count`=0, pointers 0).
  - No request is issued that cycle.
  - A response arriving in the redirect cycle is discarded.
  - Redirect has priority over pop, push and accept.
  - A redirect while in DRAIN updates `pc` and stays in DRAIN.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state IDLE, `count`=0.
  - `ibus_req_o`=0, `ibus_addr_o`=`RESET_PC`.
  - `inst_o`=NOP, `inst_addr_o`=0, `inst_valid_o`=0.
- `ibus_req_o` first rises in the cycle after `rst` deasserts.
- Latency `ibus_rvalid_i` → `inst_valid_o`: 1 cycle (registered queue), 0 cycles with bypass (see Configuration).
- Peak throughput is 1 instruction per 2 cycles when `gnt` is immediate and `rvalid` follows 1 cycle later.
- Reset mid-transaction: all state clears immediately. A late `ibus_rvalid_i` after reset arrives while in IDLE and is ignored. The bus slave is required to abort on reset.
- `ibus_rvalid_i` while in IDLE is ignored.

## Configuration
- `FETCH_BYPASS_EN` defined: when `count`==0 and a non-discarded response arrives, `inst_o`/`inst_addr_o`/`inst_valid_o` are driven combinationally from the bus that cycle.
  - If `~hold_i`, the word is consumed and not pushed.
  - If `hold_i`, the word is pushed.
- Not defined: every response goes through the queue, with 1-cycle latency.

## Test plan
- Reset release, `gnt`=1 always, `rvalid` 1 cycle after accept, words A0..A3 → fetch addrs 0,4,8,C; `inst_valid_o` pulses with `inst_addr_o` 0,4,8,C in order; `inst_o` matches data.
- `hold_i`=1 for 10 cycles → `count` reaches 2, `ibus_req_o` stays 0. Release `hold_i` → entries 0 then 4 pop in consecutive cycles, then fetching resumes at 8.
- Redirect to 32'h100 while in WAIT, `rvalid` 2 cycles later → that response is discarded, queue empty, next request addr 32'h100, `inst_valid_o` low until 32'h100 returns.
- Redirect to 32'h200 in the same cycle as `rvalid` and a pop → nothing pushed, `count`=0, next `ibus_addr_o`=32'h200.
- Assert `rst` low while in WAIT with `count`=1 → outputs immediately at reset values. After release, first request at `RESET_PC`.
- With `FETCH_BYPASS_EN`, empty queue, `hold_i`=0, response 32'h0050_0093 at `rvalid` → `inst_valid_o`=1 and `inst_o`=32'h0050_0093 in the same cycle; `count` remains 0.
